mmio_uart_tx: RTL

- Memory-mapped UART transmitter on the data-store bus of the single-cycle RISC-V top level.
- Snoops the core's store outputs (MemWrite, DataAdr, WriteData), alongside the data memory that consumes the same signals.
- Stores to its TX address are queued in a small FIFO and serialised as 8N1 frames on a single tx line.
- A control address clears the sticky overflow flag; status bits are exported as outputs for testbench and board observation.

---
 rtl/mmio_uart_tx.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter snooping the core's store bus.
// Stores to TX_ADDR are queued in a small FIFO and shifted out LSB first.
// Stores to CTRL_ADDR with bit 0 set clear the sticky overflow flag.
module mmio_uart_tx #(
    parameter logic [31:0] TX_ADDR      = 32'h0000_0100,
    parameter logic [31:0] CTRL_ADDR    = 32'h0000_0104,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic        tx,
    output logic        busy,
    output logic        fifo_full,
    output logic        overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_r;
    logic [BW-1:0]   baud_r;
    logic [2:0]      bit_r;
    logic [7:0]      shift_r;
    logic            tx_r;
    logic            busy_r;
    logic            full_r;
    logic            ovf_r;
    logic [CW-1:0]   count_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [7:0]      mem_r [FIFO_DEPTH];

    logic            tx_hit_s;
    logic            clr_s;
    logic            full_s;
    logic            push_s;
    logic            drop_s;
    logic            has_data_s;
    logic            baud_done_s;
    logic            pop_s;
    logic            go_idle_s;
    logic            busy_nxt_s;
    logic [CW-1:0]   count_nxt_s;
    logic            unused_s;

    // Only the low data byte and bit 0 matter; the rest of the store word is ignored.
    assign unused_s = ^WriteData[31:8];

    // Bus decode and FIFO handshake; fullness is judged on the pre-edge count,
    // so a store while full is dropped even if a pop happens on the same edge.
    assign tx_hit_s    = MemWrite && (DataAdr == TX_ADDR);
    assign clr_s       = MemWrite && (DataAdr == CTRL_ADDR) && WriteData[0];
    assign full_s      = (count_r == DEPTH_C);
    assign push_s      = tx_hit_s && !full_s;
    assign drop_s      = tx_hit_s && full_s;
    assign has_data_s  = (count_r != {CW{1'b0}});
    assign baud_done_s = (baud_r == BAUD_LAST);
    assign pop_s       = has_data_s && ((state_r == IDLE) || ((state_r == STOP) && baud_done_s));
    assign go_idle_s   = (state_r == STOP) && baud_done_s && !has_data_s;
    assign busy_nxt_s  = ((state_r != IDLE) && !go_idle_s) ||
                         ((state_r == IDLE) && pop_s) ||
                         (count_nxt_s != {CW{1'b0}});

    // Next FIFO occupancy from the push/pop pair.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1'b1);
            2'b01:   count_nxt_s = count_r - CW'(1'b1);
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= WriteData[7:0];
        end
    end

    // FIFO pointers, occupancy and the registered status flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b0;
            ovf_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == DEPTH_C);
            busy_r  <= busy_nxt_s;
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (clr_s) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Frame sequencer: start bit, eight data bits LSB first, stop bit; back-to-back
    // frames chain from STOP straight into START without an idle cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
            baud_r  <= {BW{1'b0}};
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            tx_r    <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (has_data_s) begin
                        shift_r <= mem_r[rd_ptr_r];
                        tx_r    <= 1'b0;
                        baud_r  <= {BW{1'b0}};
                        state_r <= START;
                    end else begin
                        tx_r <= 1'b1;
                    end
                end
                START: begin
                    if (baud_done_s) begin
                        tx_r    <= shift_r[0];
                        bit_r   <= 3'd0;
                        baud_r  <= {BW{1'b0}};
                        state_r <= DATA;
                    end else begin
                        baud_r <= baud_r + BW'(1'b1);
                    end
                end
                DATA: begin
                    if (baud_done_s) begin
                        baud_r <= {BW{1'b0}};
                        if (bit_r == 3'd7) begin
                            tx_r    <= 1'b1;
                            state_r <= STOP;
                        end else begin
                            bit_r   <= bit_r + 3'd1;
                            shift_r <= {1'b0, shift_r[7:1]};
                            tx_r    <= shift_r[1];
                        end
                    end else begin
                        baud_r <= baud_r + BW'(1'b1);
                    end
                end
                STOP: begin
                    if (baud_done_s) begin
                        baud_r <= {BW{1'b0}};
                        if (has_data_s) begin
                            shift_r <= mem_r[rd_ptr_r];
                            tx_r    <= 1'b0;
                            state_r <= START;
                        end else begin
                            tx_r    <= 1'b1;
                            state_r <= IDLE;
                        end
                    end else begin
                        baud_r <= baud_r + BW'(1'b1);
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    baud_r  <= {BW{1'b0}};
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign tx        = tx_r;
    assign busy      = busy_r;
    assign fifo_full = full_r;
    assign overflow  = ovf_r;

endmodule
